// File: rtl/pipelined_rca_pkg.sv
// pipelined_rca shared helpers: chunk width and parameter legality.
// Imported by the pipelined_rca top level.
package pipelined_rca_pkg;

  function automatic int chunk_w(input int w, input int s);
    return (s > 0) ? w / s : w;
  endfunction

  function automatic bit rca_legal(input int w, input int s);
    return (s >= 1) && (s <= w) && (w % s == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational ripple of W full adders.
// c_msb_in exposes the carry into the top bit for overflow detection.
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[W];
  assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// pipelined_rca: STAGES-deep ripple-carry adder with valid/ready flow.
// Define PIPE_RCA_SUB_EN to add the sub port (A - B).
module pipelined_rca
  import pipelined_rca_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef PIPE_RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = chunk_w(WIDTH, STAGES);

  if (!rca_legal(WIDTH, STAGES)) begin : g_bad
    $error("pipelined_rca: WIDTH must be a multiple of STAGES");
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             cx;
  logic             v0;
  logic             c0;
  logic [STAGES:0]  vq;
  logic [STAGES:0]  cq;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPE_RCA_SUB_EN
  assign bx = sub ? ~B : B;
  assign cx = sub ? 1'b1 : cin;
`else
  assign bx = B;
  assign cx = cin;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      c0 <= 1'b0;
    end else if (adv) begin
      v0 <= in_valid && in_ready;
      c0 <= cx;
    end
  end

  assign vq[0] = v0;
  assign cq[0] = c0;

  // chunk k: operands wait k+1 edges, its sum waits STAGES-k edges
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * C;
    localparam int DS = STAGES - 1 - k;

    logic [C-1:0] ad [0:k];
    logic [C-1:0] bd [0:k];
    logic [C-1:0] sd [0:DS];
    logic [C-1:0] s_w;
    logic         co_w;
    logic         cm_w;
    logic         v_q;
    logic         c_q;

    rca_chunk #(.W(C)) u_chunk (
      .a        (ad[k]),
      .b        (bd[k]),
      .ci       (cq[k]),
      .s        (s_w),
      .co       (co_w),
      .c_msb_in (cm_w)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= k; i++) begin
          ad[i] <= '0;
          bd[i] <= '0;
        end
        for (int i = 0; i <= DS; i++) sd[i] <= '0;
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (adv) begin
        ad[0] <= A[LO +: C];
        bd[0] <= bx[LO +: C];
        for (int i = 1; i <= k; i++) begin
          ad[i] <= ad[i-1];
          bd[i] <= bd[i-1];
        end
        sd[0] <= s_w;
        for (int i = 1; i <= DS; i++) sd[i] <= sd[i-1];
        v_q <= vq[k];
        c_q <= co_w;
      end
    end

    assign vq[k+1]      = v_q;
    assign cq[k+1]      = c_q;
    assign sum[LO +: C] = sd[DS];

    if (k == STAGES - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (rst) ovf <= 1'b0;
        else if (adv) ovf <= cm_w ^ co_w;
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = cm_w;
    end
  end

  assign out_valid = vq[STAGES];
  assign cout      = cq[STAGES];

endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed and random checks against an arithmetic model.
// Define PIPE_RCA_SUB_EN to exercise subtraction at WIDTH=32, STAGES=4.
module tb_pipelined_rca;

`ifdef PIPE_RCA_SUB_EN
  localparam int W = 32;
  localparam int S = 4;
`else
  localparam int W = 8;
  localparam int S = 2;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         cin;
  logic         sub_v;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  logic [W+1:0] exp_q [$];

  always #5 clk = ~clk;

  pipelined_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
`ifdef PIPE_RCA_SUB_EN
    .sub       (sub_v),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // {ovf, cout, sum} from plain arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic c,
                                         input logic s);
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   r;
    logic         o;
    bb = s ? ~b : b;
    cc = s ? 1'b1 : c;
    r  = {1'b0, a} + {1'b0, bb} + (W+1)'(cc);
    o  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return {o, r};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // one clock: score transfers seen before the edge, then advance
  task automatic tick();
    logic ix;
    logic ox;
    logic [W+1:0] e;
    #1;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (ox) begin
      chk("result_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", 64'({ovf, cout, sum}), 64'(e));
      end
    end
    if (ix) exp_q.push_back(model(A, B, cin, sub_v));
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_ops();
    A   = W'($urandom);
    B   = W'($urandom);
    cin = 1'($urandom);
`ifdef PIPE_RCA_SUB_EN
    sub_v = 1'($urandom);
`endif
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic s, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    A = a; B = b; cin = c; sub_v = s;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < S; i++) begin
      tick();
      chk({tag, "_early"}, 64'(out_valid), 64'(0));
    end
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_ovf"}, 64'(ovf), 64'(eo));
    tick();
  endtask

  task automatic drain(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < S + 2; i++) tick();
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    logic [W+2:0] snap;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; cin = 1'b0; sub_v = 1'b0;

    tick();
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    rst = 1'b0;

    directed("inc", W'(1), W'(1), 1'b1, 1'b0, W'(3), 1'b0, 1'b0);
    directed("wrap", '1, W'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
    directed("ovf", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0,
             {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
`ifdef PIPE_RCA_SUB_EN
    directed("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1,
             32'hFFFF_FFFE, 1'b0, 1'b0);
    directed("sub_ovf", 32'h8000_0000, 32'd1, 1'b1, 1'b1,
             32'h7FFF_FFFF, 1'b1, 1'b1);
`endif

    // back-to-back stream of 8
    out_ready = 1'b1;
    for (int i = 0; i < S + 8; i++) begin
      in_valid = (i < 8);
      rnd_ops();
      tick();
      chk("stream_valid", 64'(out_valid), 64'((i >= S) && (i < S + 8)));
    end
    drain("stream");

    // fill, then stall for 5 cycles
    for (int i = 0; i < S + 2; i++) begin
      in_valid = 1'b1;
      rnd_ops();
      tick();
    end
    rnd_ops();
    out_ready = 1'b0;
    #1;
    snap = {out_valid, ovf, cout, sum};
    chk("stall_full", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      tick();
      chk("stall_hold", 64'({out_valid, ovf, cout, sum}), 64'(snap));
    end
    drain("stall");

    // random valid and back-pressure
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      rnd_ops();
      tick();
    end
    drain("random");

    // reset with two operations in flight
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      rnd_ops();
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_sum", 64'(sum), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < S + 2; i++) begin
      tick();
      chk("no_stale", 64'(out_valid), 64'(0));
    end

    directed("post_rst", W'(2), W'(3), 1'b0, 1'b0, W'(5), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
